div_seq: RTL and testbench
==========================

# div_seq

Parametrised multi-cycle integer divider for the RS5 execute stage. It computes the RISC-V DIV/DIVU/REM/REMU result for one operand pair at a time, retiring STEPS quotient bits per cycle. A start/ready request handshake and a valid/ack result handshake hold the result until the core consumes it. Kill aborts an in-flight operation, for example on a pipeline flush.

## Interface
- N, 32: operand and result width; even, at least 4.
- STEPS, 1: quotient bits retired per CALC cycle; must be 1, 2 or 4 and divide N.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start_i  in  1  request; accepted when start_i && ready_o.
- op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU; sampled at acceptance.
- first_operand_i  in  N  dividend; sampled at acceptance.
- second_operand_i  in  N  divisor; sampled at acceptance.
- kill_i  in  1  abort; takes priority over all except reset.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  high only in DONE.
- result_o  out  N  registered result; meaningful while valid_o.
- ack_i  in  1  result consumed; effective when valid_o && ack_i.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Signed ops: sign_a = dividend[N-1], sign_b = divisor[N-1]. Unsigned ops: both signs 0.
- IDLE accept, special cases, in priority order; each goes to DONE directly:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed op with dividend = 1<<(N-1) and divisor all-ones: quotient = dividend, remainder 0.
  - Divisor 1, any op: quotient = dividend, remainder 0.
- IDLE accept, otherwise:
  - Latch op, sign_a, sign_b.
  - Latch |dividend| and |divisor| (two's-complement negate when the sign is set).
  - acc := 0, quo := |dividend|, count := 0. Go to CALC.
- CALC, per cycle: STEPS chained restoring steps. Each step:
  - Shift {acc,quo} left 1.
  - If acc[N:0] >= {0,|divisor|}: subtract, and set quo[0] := 1.
  - acc is N+1 bits wide.
- CALC exit: count increments per cycle. After N/STEPS cycles go to FIX.
- FIX:
  - Quotient = (sign_a^sign_b) ? -quo : quo.
  - Remainder = sign_a ? -acc[N-1:0] : acc[N-1:0].
  - Select the quotient or remainder per op into result_o. Go to DONE.
- DONE: result_o held stable. On ack_i go to IDLE.
- kill_i in any state: next state IDLE, valid_o low next cycle, result discarded, no partial update of result_o. A start_i in the same cycle as kill_i is not accepted.
- reset: state IDLE, result_o 0, acc/quo/count 0.
- Operand inputs are ignored outside the acceptance cycle. Changing them mid-operation has no effect.

## Timing
- After reset: ready_o=1, valid_o=0, result_o=0.
- Accept edge E0. Normal path: CALC during E0..E0+N/STEPS, FIX one cycle.
  - valid_o rises after edge E0+N/STEPS+1.
  - Latency (accept to valid) is N/STEPS+1 cycles: 33 for N=32, STEPS=1; 9 for STEPS=4.
- Special path: valid_o high from the cycle after E0 (latency 1).
- ready_o and valid_o are never high together. Next accept is earliest the cycle after the ack edge.
- ack_i while valid_o=0 is ignored. valid_o stays high indefinitely without ack_i.
- Reset asserted mid-CALC or mid-DONE: IDLE on the next edge, identical to power-on.

## Test plan
- DIVU 100/7, N=32:
  - valid_o exactly 33 cycles after accept, result_o=14.
  - Same operands with REMU give 2.
- DIV -7/2 gives -3 (0xFFFFFFFD). REM -7/2 gives -1. REM 7/-2 gives 1.
- Specials, each valid in 1 cycle:
  - DIV 5/0 gives 0xFFFFFFFF. REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000. REM of the same gives 0.
  - DIVU 0x80000000/0xFFFFFFFF gives 0 via the normal path.
- Handshake:
  - Hold ack_i low 10 cycles after valid: result_o stable, ready_o low.
  - Ack: IDLE next cycle.
  - start_i during CALC or DONE is ignored.
- kill_i at CALC cycle 5: ready_o=1 next cycle, valid_o never rises. A following DIVU 9/3 returns 3.
- STEPS=2 and STEPS=4, N=16: random signed and unsigned pairs match the reference model. Latency is 9 and 5 respectively.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU, STEPS quotient bits per cycle.
// Request handshake start_i/ready_o, result handshake valid_o/ack_i, kill_i aborts.
module div_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] first_operand_i,
    input  logic [N-1:0] second_operand_i,
    input  logic         kill_i,
    input  logic         ack_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [N-1:0] result_o
);

    localparam int unsigned CYCLES = N / STEPS;
    localparam int unsigned CW     = $clog2(CYCLES + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_ready;
    logic           r_valid;
    logic           w_ready_nxt;
    logic           w_valid_nxt;

    logic [N:0]     r_acc;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic           r_rem;
    logic           r_sign_a;
    logic           r_sign_b;
    logic [N-1:0]   r_result;

    logic           w_accept;
    logic           w_signed;
    logic           w_sign_a;
    logic           w_sign_b;
    logic           w_div0;
    logic           w_special;
    logic [N-1:0]   w_special_res;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [N:0]     w_acc_step;
    logic [N-1:0]   w_quo_step;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;

    // Operand decode at acceptance: signs, magnitudes and the short-circuit cases
    always_comb begin
        w_accept  = (r_state == S_IDLE) && start_i && !kill_i;
        w_signed  = ~op_i[0];
        w_sign_a  = w_signed & first_operand_i[N-1];
        w_sign_b  = w_signed & second_operand_i[N-1];
        w_abs_a   = w_sign_a ? -first_operand_i  : first_operand_i;
        w_abs_b   = w_sign_b ? -second_operand_i : second_operand_i;
        w_div0    = (second_operand_i == '0);
        w_special = w_div0
                  || (w_signed && (first_operand_i == MIN_NEG) && (second_operand_i == ALL_ONES))
                  || (second_operand_i == N'(1));
        if (w_div0) begin
            w_special_res = op_i[1] ? first_operand_i : ALL_ONES;
        end else begin
            w_special_res = op_i[1] ? '0 : first_operand_i;
        end
    end

    // STEPS chained restoring steps per CALC cycle
    always_comb begin
        w_acc_step = r_acc;
        w_quo_step = r_quo;
        for (int unsigned s = 0; s < STEPS; s++) begin
            w_acc_step = {w_acc_step[N-1:0], w_quo_step[N-1]};
            w_quo_step = {w_quo_step[N-2:0], 1'b0};
            if (w_acc_step >= {1'b0, r_div}) begin
                w_acc_step    = w_acc_step - {1'b0, r_div};
                w_quo_step[0] = 1'b1;
            end
        end
    end

    always_comb begin
        w_quo_fix = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
        w_rem_fix = r_sign_a ? -r_acc[N-1:0] : r_acc[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        if (kill_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) w_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == CW'(CYCLES - 1)) w_next = S_FIX;
                S_FIX:  w_next = S_DONE;
                S_DONE: if (ack_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Handshake flags are registered alongside the state they decode
    always_comb begin
        w_ready_nxt = (w_next == S_IDLE);
        w_valid_nxt = (w_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_rem    <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            r_result <= w_special_res;
                        end else begin
                            r_rem    <= op_i[1];
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            r_div    <= w_abs_b;
                            r_acc    <= '0;
                            r_quo    <= w_abs_a;
                            r_cnt    <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (!kill_i) r_result <= r_rem ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: N=32/STEPS=1 vector table and handshake/kill/reset
// sequences, plus N=16 STEPS=2 and STEPS=4 instances checked against a native-arithmetic model.
module tb_div_seq;

    logic        clk;
    logic        reset;

    logic        start0, kill0, ack0;
    logic [1:0]  op0;
    logic [31:0] a0, b0;
    logic        ready0, valid0;
    logic [31:0] res0;

    logic        start16, kill16, ack16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        ready1, valid1, ready2, valid2;
    logic [15:0] res1, res2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb0[$];
    logic [15:0] sb1[$];
    logic [15:0] sb2[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[15];

    div_seq #(.N(32), .STEPS(1)) u_dut0 (
        .clk(clk), .reset(reset), .start_i(start0), .op_i(op0),
        .first_operand_i(a0), .second_operand_i(b0), .kill_i(kill0), .ack_i(ack0),
        .ready_o(ready0), .valid_o(valid0), .result_o(res0)
    );

    div_seq #(.N(16), .STEPS(2)) u_dut1 (
        .clk(clk), .reset(reset), .start_i(start16), .op_i(op16),
        .first_operand_i(a16), .second_operand_i(b16), .kill_i(kill16), .ack_i(ack16),
        .ready_o(ready1), .valid_o(valid1), .result_o(res1)
    );

    div_seq #(.N(16), .STEPS(4)) u_dut2 (
        .clk(clk), .reset(reset), .start_i(start16), .op_i(op16),
        .first_operand_i(a16), .second_operand_i(b16), .kill_i(kill16), .ack_i(ack16),
        .ready_o(ready2), .valid_o(valid2), .result_o(res2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, ua, ub;
        if (b == 16'd0) return op[1] ? a : 16'hFFFF;
        if (op[0] == 1'b0) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return op[1] ? 16'(sa % sb) : 16'(sa / sb);
        end
        ua = int'({16'd0, a});
        ub = int'({16'd0, b});
        return op[1] ? 16'(ua % ub) : 16'(ua / ub);
    endfunction

    function automatic bit special16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        return (b == 16'd0) || (b == 16'd1) || (!op[0] && a == 16'h8000 && b == 16'hFFFF);
    endfunction

    // Wait from just after the accept edge until valid0, counting further edges
    task automatic wait_valid0(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (valid0) got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic ack_dut0();
        ack0 = 1'b1;
        @(posedge clk);
        #1 ack0 = 1'b0;
        @(negedge clk);
        check("ready_after_ack", 32'(ready0), 32'd1);
        check("valid_after_ack", 32'(valid0), 32'd0);
    endtask

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special);
        int lat;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        check("ready_before_start", 32'(ready0), 32'd1);
        op0 = op; a0 = a; b0 = b; start0 = 1'b1;
        sb0.push_back(exp);
        @(posedge clk);
        #1 start0 = 1'b0;
        a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
        wait_valid0(lat, got);
        e = (sb0.size() > 0) ? sb0.pop_front() : 32'hDEADBEEF;
        if (!got) begin
            check("valid_timeout", 32'd0, 32'd1);
        end else begin
            check("latency32", 32'(lat), special ? 32'd0 : 32'd33);
            check("ready_valid_excl", 32'(ready0), 32'd0);
            check("result32", res0, e);
            ack_dut0();
        end
    endtask

    task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int lat, l1, l2;
        bit g1, g2, sp;
        logic [15:0] e1, e2;
        sp = special16(op, a, b);
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; start16 = 1'b1;
        sb1.push_back(ref16(op, a, b));
        sb2.push_back(ref16(op, a, b));
        @(posedge clk);
        #1 start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 2'($urandom);
        lat = 0; l1 = 0; l2 = 0; g1 = 1'b0; g2 = 1'b0;
        for (int i = 0; i < 60 && !(g1 && g2); i++) begin
            @(negedge clk);
            if (valid1 && !g1) begin g1 = 1'b1; l1 = lat; end
            if (valid2 && !g2) begin g2 = 1'b1; l2 = lat; end
            if (!(g1 && g2)) begin
                @(posedge clk);
                lat++;
            end
        end
        e1 = (sb1.size() > 0) ? sb1.pop_front() : 16'hDEAD;
        e2 = (sb2.size() > 0) ? sb2.pop_front() : 16'hDEAD;
        if (!(g1 && g2)) begin
            check("valid16_timeout", 32'({g1, g2}), 32'd3);
        end else begin
            check("latency_steps2", 32'(l1), sp ? 32'd0 : 32'd9);
            check("latency_steps4", 32'(l2), sp ? 32'd0 : 32'd5);
            check("result_steps2", 32'(res1), 32'(e1));
            check("result_steps4", 32'(res2), 32'(e2));
        end
        ack16 = 1'b1;
        @(posedge clk);
        #1 ack16 = 1'b0;
        @(negedge clk);
        check("idle16", 32'({ready1, valid1, ready2, valid2}), 32'b1010);
    endtask

    initial begin
        int lat;
        bit got;
        bit seen;
        logic [31:0] e;
        logic [1:0]  rop;
        logic [15:0] ra, rb;
        int mode;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
        vecs[4]  = '{2'd2, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0};
        vecs[5]  = '{2'd0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
        vecs[6]  = '{2'd0, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[7]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[8]  = '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[9]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1};
        vecs[10] = '{2'd1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[11] = '{2'd1, 32'd12345,      32'd1,          32'd12345,      1'b1};
        vecs[12] = '{2'd2, 32'hFFFFFFF9,   32'd1,          32'd0,          1'b1};
        vecs[13] = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0};
        vecs[14] = '{2'd3, 32'hFFFFFFFF,   32'd10,         32'd5,          1'b0};

        reset = 1'b1;
        start0 = 1'b0; kill0 = 1'b0; ack0 = 1'b0; op0 = 2'd0; a0 = '0; b0 = '0;
        start16 = 1'b0; kill16 = 1'b0; ack16 = 1'b0; op16 = 2'd0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready0), 32'd1);
        check("reset_valid", 32'(valid0), 32'd0);
        check("reset_result", res0, 32'd0);
        check("reset_ready16", 32'({ready1, ready2}), 32'd3);

        for (int i = 0; i < 15; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special);
        end

        // start held high through CALC and DONE must not start a second operation
        @(negedge clk);
        op0 = 2'd1; a0 = 32'd100; b0 = 32'd7; start0 = 1'b1;
        sb0.push_back(32'd14);
        @(posedge clk);
        #1 op0 = 2'd0; a0 = 32'd1000; b0 = 32'd10;
        wait_valid0(lat, got);
        e = (sb0.size() > 0) ? sb0.pop_front() : 32'hDEADBEEF;
        check("hold_valid_seen", 32'(got), 32'd1);
        check("hold_latency", 32'(lat), 32'd33);
        check("hold_result", res0, e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_stable_result", res0, 32'd14);
            check("hold_ready_low", 32'(ready0), 32'd0);
            check("hold_valid_high", 32'(valid0), 32'd1);
        end
        start0 = 1'b0;
        ack_dut0();
        ack0 = 1'b1;
        repeat (2) @(negedge clk);
        ack0 = 1'b0;
        check("ack_in_idle_ignored", 32'({ready0, valid0}), 32'b10);

        // kill mid-CALC
        @(negedge clk);
        op0 = 2'd1; a0 = 32'd100; b0 = 32'd7; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill0 = 1'b1;
        @(posedge clk);
        #1 kill0 = 1'b0;
        @(negedge clk);
        check("kill_ready", 32'(ready0), 32'd1);
        check("kill_valid", 32'(valid0), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid0) seen = 1'b1;
        end
        check("kill_no_valid", 32'(seen), 32'd0);

        // start together with kill is not accepted
        @(negedge clk);
        op0 = 2'd1; a0 = 32'd9; b0 = 32'd3; start0 = 1'b1; kill0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0; kill0 = 1'b0;
        @(negedge clk);
        check("start_kill_ready", 32'(ready0), 32'd1);
        check("start_kill_valid", 32'(valid0), 32'd0);
        run32(2'd1, 32'd9, 32'd3, 32'd3, 1'b0);

        // kill in DONE, then kill in FIX: result register left untouched
        @(negedge clk);
        op0 = 2'd0; a0 = 32'd5; b0 = 32'd0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        check("special_valid_1cyc", 32'(valid0), 32'd1);
        kill0 = 1'b1;
        @(posedge clk);
        #1 kill0 = 1'b0;
        @(negedge clk);
        check("kill_done_ready", 32'(ready0), 32'd1);
        check("kill_done_valid", 32'(valid0), 32'd0);
        op0 = 2'd1; a0 = 32'd100; b0 = 32'd7; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (32) @(posedge clk);
        @(negedge clk);
        kill0 = 1'b1;
        @(posedge clk);
        #1 kill0 = 1'b0;
        @(negedge clk);
        check("kill_fix_valid", 32'(valid0), 32'd0);
        check("kill_fix_result_kept", res0, 32'hFFFFFFFF);

        // reset mid-CALC and mid-DONE
        @(negedge clk);
        op0 = 2'd1; a0 = 32'd100; b0 = 32'd7; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_calc_ready", 32'(ready0), 32'd1);
        check("rst_calc_valid", 32'(valid0), 32'd0);
        check("rst_calc_result", res0, 32'd0);
        op0 = 2'd0; a0 = 32'd5; b0 = 32'd0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        check("rst_done_pre_valid", 32'(valid0), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_done_ready", 32'(ready0), 32'd1);
        check("rst_done_valid", 32'(valid0), 32'd0);
        check("rst_done_result", res0, 32'd0);
        run32(2'd1, 32'd100, 32'd7, 32'd14, 1'b0);

        // N=16 random pairs, biased toward the short-circuit cases
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            rop = 2'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (mode)
                0: rb = 16'd0;
                1: rb = 16'd1;
                2: begin ra = 16'h8000; rb = 16'hFFFF; end
                3: rb = 16'($urandom_range(2, 20));
                default: ;
            endcase
            run16(rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
